// File: rtl/regfile_wb_arbiter_if.sv
// Writeback-side bundle between the execution units, the register file
// write port and the decode-stage scoreboard.
interface regfile_wb_arbiter_if #(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned XLEN  = 32
);
  logic [N_SRC-1:0]      src_valid;
  logic [5*N_SRC-1:0]    src_rd;
  logic [XLEN*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]      src_ready;
  logic                  rf_wr_en;
  logic [4:0]            rf_rd_addr;
  logic [XLEN-1:0]       rf_wr_data;
  logic                  iss_valid;
  logic [4:0]            iss_rd;
  logic                  flush;
  logic [31:0]           busy_mask;

  modport master (
    output src_valid, src_rd, src_data, iss_valid, iss_rd, flush,
    input  src_ready, rf_wr_en, rf_rd_addr, rf_wr_data, busy_mask
  );

  modport slave (
    input  src_valid, src_rd, src_data, iss_valid, iss_rd, flush,
    output src_ready, rf_wr_en, rf_rd_addr, rf_wr_data, busy_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the integer register file write port, plus the
// pending-write scoreboard used by decode for RAW stall detection.
module regfile_wb_arbiter #(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned XLEN  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  wb
);
  localparam int unsigned PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PW-1:0]    r_ptr;
  logic             r_wr_en;
  logic [4:0]       r_rd_addr;
  logic [XLEN-1:0]  r_wr_data;
  logic [31:0]      r_busy;

  logic [N_SRC-1:0] w_grant;
  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_gnt_idx;
  logic             w_found;
  logic [4:0]       w_sel_rd;
  logic [XLEN-1:0]  w_sel_data;
  logic [PW-1:0]    w_ptr_nxt;
  logic [31:0]      w_busy_nxt;

  // First valid source searching upward from the pointer, with wrap.
  always_comb begin
    w_grant   = '0;
    w_idx     = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      w_idx = PW'((32'(r_ptr) + k) % N_SRC);
      if (!w_found && wb.src_valid[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_gnt_idx      = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (w_grant[k]) begin
        w_sel_rd   = wb.src_rd[5*k +: 5];
        w_sel_data = wb.src_data[XLEN*k +: XLEN];
      end
    end
  end

  always_comb begin
    w_ptr_nxt = (w_gnt_idx == PW'(N_SRC - 1)) ? '0 : PW'(w_gnt_idx + 1'b1);
  end

  // Flush beats clear and set; a same-cycle set beats clear (newer issue).
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_found && (w_sel_rd != 5'd0)) begin
      w_busy_nxt[w_sel_rd] = 1'b0;
    end
    if (wb.iss_valid && (wb.iss_rd != 5'd0)) begin
      w_busy_nxt[wb.iss_rd] = 1'b1;
    end
    if (wb.flush) begin
      w_busy_nxt = '0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= '0;
    end else begin
      r_wr_en <= w_found && (w_sel_rd != 5'd0);
      r_busy  <= w_busy_nxt;
      if (w_found) begin
        r_ptr     <= w_ptr_nxt;
        r_rd_addr <= w_sel_rd;
        r_wr_data <= w_sel_data;
      end
    end
  end

  // Grants are suppressed while reset is asserted.
  assign wb.src_ready  = rst_n ? w_grant : '0;
  assign wb.rf_wr_en   = r_wr_en;
  assign wb.rf_rd_addr = r_rd_addr;
  assign wb.rf_wr_data = r_wr_data;
  assign wb.busy_mask  = r_busy;
endmodule
